sum_squares_seq: RTL and testbench

SUM_SQUARES_SEQ -- requirements
Module: sum_squares_seq

---
 rtl/sum_squares_seq.sv | 90 +++++++++
 tb/tb_sum_squares_seq.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_squares_seq.sv
// Sequential sum-of-squares accumulator: K unsigned W-bit samples are squared and summed into an
// N-bit result that saturates at 2^N-1, with a sticky saturation flag and a result-valid strobe.
module sum_squares_seq #(
    parameter int W = 4,
    parameter int K = 4,
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic [N-1:0] O,
    output logic         sat,
    output logic         ready
);

    localparam int CW = (K > 1) ? $clog2(K) : 1;
    // The adder is one bit wider than the larger of the accumulator and the square, so no carry is lost
    localparam int SW = ((2 * W > N) ? 2 * W : N) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CLEAR = 2'b01,
        ACC   = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t          state_q;
    logic [N-1:0]    acc_q;
    logic            sat_int_q;
    logic [CW-1:0]   count_q;

    logic [2*W-1:0]  din_ext;
    logic [2*W-1:0]  sq;
    logic [SW-1:0]   sum_d;
    logic            ovf_d;
    logic [N-1:0]    acc_d;

    always_comb begin
        din_ext  = {{W{1'b0}}, in_data};
        sq       = din_ext * din_ext;
        sum_d    = SW'(acc_q) + SW'(sq);
        ovf_d    = |sum_d[SW-1:N];
        acc_d    = ovf_d ? '1 : sum_d[N-1:0];
        in_ready = (state_q == ACC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            sat_int_q <= 1'b0;
            count_q   <= '0;
            O         <= '0;
            sat       <= 1'b0;
            ready     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) state_q <= CLEAR;
                end
                CLEAR: begin
                    ready     <= 1'b0;
                    acc_q     <= '0;
                    sat_int_q <= 1'b0;
                    count_q   <= '0;
                    state_q   <= ACC;
                end
                ACC: begin
                    if (in_valid) begin
                        acc_q     <= acc_d;
                        sat_int_q <= sat_int_q | ovf_d;
                        count_q   <= count_q + CW'(1);
                        if (count_q == CW'(K - 1)) state_q <= DONE;
                    end
                end
                DONE: begin
                    O       <= acc_q;
                    sat     <= sat_int_q;
                    ready   <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sum_squares_seq.sv
// Scoreboard bench for sum_squares_seq: a reference model pushes expected results as samples are
// driven; each scenario task pops and compares when ready rises.
module tb_sum_squares_seq;

    localparam int W = 4;
    localparam int K = 4;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic [N-1:0] O;
    logic         sat;
    logic         ready;

    int checks = 0;
    int fails  = 0;
    int edges  = 0;

    typedef struct {
        logic [N-1:0] o;
        logic         s;
    } exp_t;

    exp_t sb[$];

    sum_squares_seq #(.W(W), .K(K), .N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .O        (O),
        .sat      (sat),
        .ready    (ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    // Inputs change and outputs are sampled 1 time unit after each rising edge
    task automatic tick();
        @(posedge clk);
        #1;
        edges++;
    endtask

    // Drives one full operation of 4 samples and pushes the model's expected result.
    // samples packed as {s3,s2,s1,s0}; gap idle cycles with in_valid=0 after each of the first 3 transfers.
    task automatic run_op(input logic [4*W-1:0] samples, input int gap, input bit pulse_ignored,
                          output int lat, output bit tmo, output int stall_bad,
                          output logic r0, output logic [N-1:0] o0, output logic r1);
        int unsigned macc;
        bit msat;
        int e0;
        int b;
        exp_t e;
        macc = 0; msat = 0; tmo = 0; stall_bad = 0; lat = 0;
        e0 = edges;
        start = 1'b1;
        tick();
        start = 1'b0;
        r0 = ready;
        o0 = O;
        in_valid = 1'b1;
        in_data  = samples[0 +: W];
        tick();
        r1 = ready;
        for (int i = 0; i < K; i++) begin
            in_valid = 1'b1;
            in_data  = samples[i*W +: W];
            b = 0;
            while (in_ready !== 1'b1 && b < 20) begin
                tick();
                b++;
            end
            if (b >= 20) tmo = 1;
            macc = macc + int'(in_data) * int'(in_data);
            if (macc > 255) begin
                macc = 255;
                msat = 1;
            end
            if (pulse_ignored && i == 0) start = 1'b1;
            tick();
            start = 1'b0;
            if (i < K - 1) begin
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0;
                    in_data  = 4'hF;
                    tick();
                    if (in_ready !== 1'b1) stall_bad++;
                end
            end
        end
        in_valid = 1'b0;
        e.o = N'(macc);
        e.s = msat;
        sb.push_back(e);
        if (pulse_ignored) start = 1'b1;
        b = 0;
        while (ready !== 1'b1 && b < 20) begin
            tick();
            start = 1'b0;
            b++;
        end
        start = 1'b0;
        if (b >= 20) tmo = 1;
        lat = edges - e0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 4'hF;
        tick();
        tick();
        checks++;
        if (O !== '0 || sat !== 1'b0 || ready !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: O=%0d sat=%b ready=%b in_ready=%b, required all 0", O, sat, ready, in_ready);
        end
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0 || ready !== 1'b0) begin
            fails++;
            $display("FAIL idle_no_start: in_ready=%b ready=%b, required 0 0", in_ready, ready);
        end
    endtask

    task automatic test_basic();
        int lat, sb_bad; bit tmo; logic r0, r1; logic [N-1:0] o0; exp_t e;
        run_op({4'd4, 4'd3, 4'd2, 4'd1}, 0, 0, lat, tmo, sb_bad, r0, o0, r1);
        e = sb.pop_front();
        checks++;
        if (tmo || O !== e.o || sat !== e.s) begin
            fails++;
            $display("FAIL basic_result: O=%0d sat=%b tmo=%b, required O=%0d sat=%b", O, sat, tmo, e.o, e.s);
        end
        checks++;
        if (lat !== 7) begin
            fails++;
            $display("FAIL basic_latency: ready after %0d edges, required 7", lat);
        end
        checks++;
        if (O !== 8'd30) begin
            fails++;
            $display("FAIL basic_const: O=%0d, required 30", O);
        end
    endtask

    task automatic test_saturation();
        int lat, sb_bad; bit tmo; logic r0, r1; logic [N-1:0] o0; exp_t e;
        run_op({4'd15, 4'd15, 4'd15, 4'd15}, 0, 0, lat, tmo, sb_bad, r0, o0, r1);
        e = sb.pop_front();
        checks++;
        if (tmo || O !== e.o || sat !== e.s || O !== 8'd255 || sat !== 1'b1) begin
            fails++;
            $display("FAIL sat_all15: O=%0d sat=%b, required O=255 sat=1", O, sat);
        end
        run_op({4'd0, 4'd0, 4'd15, 4'd15}, 0, 0, lat, tmo, sb_bad, r0, o0, r1);
        e = sb.pop_front();
        checks++;
        if (tmo || O !== e.o || sat !== e.s || O !== 8'd255 || sat !== 1'b1) begin
            fails++;
            $display("FAIL sat_sticky: O=%0d sat=%b, required O=255 sat=1", O, sat);
        end
        run_op({4'd1, 4'd0, 4'd10, 4'd11}, 0, 0, lat, tmo, sb_bad, r0, o0, r1);
        e = sb.pop_front();
        checks++;
        if (tmo || O !== e.o || sat !== e.s) begin
            fails++;
            $display("FAIL sat_cleared: O=%0d sat=%b, required O=%0d sat=%b", O, sat, e.o, e.s);
        end
    endtask

    task automatic test_stalls();
        int lat, sb_bad; bit tmo; logic r0, r1; logic [N-1:0] o0; exp_t e;
        run_op({4'd1, 4'd3, 4'd0, 4'd2}, 2, 0, lat, tmo, sb_bad, r0, o0, r1);
        e = sb.pop_front();
        checks++;
        if (tmo || O !== e.o || sat !== e.s || O !== 8'd14) begin
            fails++;
            $display("FAIL stall_result: O=%0d sat=%b, required O=14 sat=0", O, sat);
        end
        checks++;
        if (sb_bad !== 0 || lat !== 13) begin
            fails++;
            $display("FAIL stall_hold: bad_stall_cycles=%0d latency=%0d, required 0 and 13", sb_bad, lat);
        end
    endtask

    task automatic test_ignored_start();
        int lat, sb_bad, bad; bit tmo; logic r0, r1; logic [N-1:0] o0; exp_t e;
        run_op({4'd4, 4'd3, 4'd2, 4'd1}, 0, 1, lat, tmo, sb_bad, r0, o0, r1);
        e = sb.pop_front();
        checks++;
        if (tmo || O !== e.o || sat !== e.s || lat !== 7) begin
            fails++;
            $display("FAIL ignored_start_result: O=%0d sat=%b lat=%0d, required O=%0d sat=%b lat=7", O, sat, lat, e.o, e.s);
        end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (in_ready !== 1'b0 || ready !== 1'b1 || O !== 8'd30) bad++;
        end
        checks++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL ignored_start_no_rerun: bad_cycles=%0d, required 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        int lat, sb_bad; bit tmo; logic r0, r1; logic [N-1:0] o0; exp_t e;
        run_op({4'd4, 4'd3, 4'd2, 4'd1}, 0, 0, lat, tmo, sb_bad, r0, o0, r1);
        e = sb.pop_front();
        tick();
        tick();
        checks++;
        if (tmo || O !== e.o || ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_first_hold: O=%0d ready=%b, required O=%0d ready=1", O, ready, e.o);
        end
        run_op({4'd5, 4'd5, 4'd5, 4'd5}, 0, 0, lat, tmo, sb_bad, r0, o0, r1);
        checks++;
        if (r0 !== 1'b1 || o0 !== 8'd30 || r1 !== 1'b0) begin
            fails++;
            $display("FAIL b2b_ready_drop: after_start ready=%b O=%0d, after_clear ready=%b; required 1 30 0", r0, o0, r1);
        end
        e = sb.pop_front();
        checks++;
        if (tmo || O !== e.o || sat !== e.s || O !== 8'd100) begin
            fails++;
            $display("FAIL b2b_second: O=%0d sat=%b, required O=100 sat=0", O, sat);
        end
    endtask

    task automatic test_mid_reset();
        int lat, sb_bad; bit tmo; logic r0, r1; logic [N-1:0] o0; exp_t e;
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 4'd7;
        tick();
        tick();
        tick();
        rst = 1'b1;
        start = 1'b1;
        tick();
        checks++;
        if (O !== '0 || sat !== 1'b0 || ready !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_clear: O=%0d sat=%b ready=%b in_ready=%b, required all 0", O, sat, ready, in_ready);
        end
        rst = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0 || ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_priority: in_ready=%b ready=%b, required 0 0", in_ready, ready);
        end
        run_op({4'd1, 4'd1, 4'd1, 4'd1}, 0, 0, lat, tmo, sb_bad, r0, o0, r1);
        e = sb.pop_front();
        checks++;
        if (tmo || O !== e.o || sat !== e.s || O !== 8'd4) begin
            fails++;
            $display("FAIL mid_reset_new_op: O=%0d sat=%b, required O=4 sat=0", O, sat);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        test_reset();
        test_basic();
        test_saturation();
        test_stalls();
        test_ignored_start();
        test_back_to_back();
        test_mid_reset();
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", checks, fails);
        $finish;
    end

endmodule
